// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the main-memory arbiter: FSM state encodings and
// the owner encoding used for tie-breaking and data routing.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

endpackage

// File: rtl/outstanding_ctr.sv
// Up/down counter of in-flight memory reads. It stops at 0 and at MAX and
// exposes full/empty flags to the arbiter.
module outstanding_ctr #(
    parameter int MAX = 4,
    parameter int W   = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] count;
    logic         dec_ok;

    // A data-valid with nothing in flight is spurious and must not underflow.
    assign dec_ok = dec & ~empty;
    assign full   = (count == MAX_CNT);
    assign empty  = (count == '0);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !dec_ok && !full) begin
            count <= count + 1'b1;
        end else if (dec_ok && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the pipelined main memory between the I-cache and D-cache refill
// FSMs: one owner at a time, held until it drops its request, no preemption.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic              mem_data_vld,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic              i_data_vld,
    output logic              d_data_vld,
    output logic              i_pause,
    output logic              d_pause
);

    arb_state_t state, state_nxt;
    owner_t     last_owner, last_owner_nxt;

    logic gnt_i_st, gnt_d_st;
    logic cnt_full, cnt_empty;
    logic throttle, vld_ok;

    assign gnt_i_st = (state == ST_GNT_I);
    assign gnt_d_st = (state == ST_GNT_D);
    assign throttle = (gnt_i_st | gnt_d_st) & cnt_full & ~mem_data_vld;
    assign vld_ok   = mem_data_vld & ~cnt_empty;

    outstanding_ctr #(
        .MAX (MAX_OUT),
        .W   (CNT_W)
    ) u_outstanding (
        .clk   (clk),
        .rst   (rst),
        .inc   (mem_en & ~mem_wr),
        .dec   (mem_data_vld),
        .full  (cnt_full),
        .empty (cnt_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_owner <= OWN_I;
        end else begin
            state      <= state_nxt;
            last_owner <= last_owner_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt      = state;
        last_owner_nxt = last_owner;
        case (state)
            ST_IDLE: begin
                // On a tie the requester that did not own memory last wins.
                if (i_req && d_req) begin
                    state_nxt = (last_owner == OWN_D) ? ST_GNT_I : ST_GNT_D;
                end else if (d_req) begin
                    state_nxt = ST_GNT_D;
                end else if (i_req) begin
                    state_nxt = ST_GNT_I;
                end
            end
            ST_GNT_I: begin
                if (!i_req) begin
                    last_owner_nxt = OWN_I;
                    state_nxt      = cnt_empty ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_GNT_D: begin
                if (!d_req) begin
                    last_owner_nxt = OWN_D;
                    state_nxt      = cnt_empty ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_empty) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        mem_en     = 1'b0;
        mem_wr     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        i_grant    = gnt_i_st;
        d_grant    = gnt_d_st;
        i_data_vld = 1'b0;
        d_data_vld = 1'b0;
        case (state)
            ST_GNT_I: begin
                mem_en     = i_req & ~throttle;
                mem_addr   = i_addr;
                i_data_vld = vld_ok;
            end
            ST_GNT_D: begin
                mem_en     = d_req & ~throttle;
                mem_wr     = d_wr;
                mem_addr   = d_addr;
                mem_wdata  = d_wdata;
                d_data_vld = vld_ok;
            end
            ST_DRAIN: begin
                // Late read data still belongs to the owner that just released.
                i_data_vld = vld_ok & (last_owner == OWN_I);
                d_data_vld = vld_ok & (last_owner == OWN_D);
            end
            default: ;
        endcase
        // Pauses are masked during reset so every output reads 0 while it is held.
        i_pause = ~rst & ((i_req & ~gnt_i_st) | (gnt_i_st & throttle));
        d_pause = ~rst & ((d_req & ~gnt_d_st) | (gnt_d_st & throttle));
    end

endmodule
